// File: rtl/pads_oe_sequencer_if.sv
// Host request bus of the pad output-enable sequencer.
interface pads_oe_sequencer_if #(
  parameter int unsigned NPAD = 44
);
  logic            req_valid;
  logic            req_ready;
  logic [NPAD-1:0] req_oen;
  logic [NPAD-1:0] req_mask;
  logic [NPAD-1:0] lock_mask;

  modport master (
    output req_valid,
    output req_oen,
    output req_mask,
    output lock_mask,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_oen,
    input  req_mask,
    input  lock_mask,
    output req_ready
  );
endinterface

// File: rtl/pads_oe_sequencer.sv
// Break-before-make sequencer for pad direction changes: release outputs, settle, then drive.
// Keeps a shadow of every pad OEN (1 = input) and honours per-pad locks.
module pads_oe_sequencer #(
  parameter int unsigned     NPAD    = 44,
  parameter int unsigned     SETTLE  = 4,
  parameter int unsigned     CNTW    = 3,
  parameter logic [NPAD-1:0] RST_OEN = 44'hC70_003F_FFBD
) (
  input  logic                 clk,
  input  logic                 reset,
  pads_oe_sequencer_if.slave   host,
  output logic [NPAD-1:0]      cnfg_io,
  output logic [NPAD-1:0]      cnfg_en,
  output logic [NPAD-1:0]      cur_oen,
  output logic                 busy,
  output logic                 done,
  output logic                 lock_hit
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REL  = 3'd1,
    WAIT = 3'd2,
    DRV  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [NPAD-1:0] rel_q, rel_d;
  logic [NPAD-1:0] drv_q, drv_d;
  logic [NPAD-1:0] io_d, en_d, cur_d;
  logic            ready_q, ready_d;
  logic            busy_d, done_d, lock_hit_d;

  logic            acc_c;
  logic [NPAD-1:0] eff_c, rel_c, drv_c;

  assign host.req_ready = ready_q;

  // Request decode against the current shadow: only pads that actually flip get strobed
  assign acc_c = host.req_valid & ready_q;
  assign eff_c = host.req_mask & ~host.lock_mask;
  assign rel_c = eff_c &  host.req_oen & ~cur_oen;
  assign drv_c = eff_c & ~host.req_oen &  cur_oen;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the values every registered output takes in that state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rel_d      = rel_q;
    drv_d      = drv_q;
    io_d       = cnfg_io;
    lock_hit_d = lock_hit;

    case (state_q)
      IDLE: begin
        if (acc_c) begin
          rel_d      = rel_c;
          drv_d      = drv_c;
          io_d       = host.req_oen;
          lock_hit_d = |(host.req_mask & host.lock_mask);
          if (|rel_c)      state_d = REL;
          else if (|drv_c) state_d = DRV;
          else             state_d = DONE;
        end
      end
      REL: begin
        state_d = WAIT;
        cnt_d   = CNTW'(SETTLE - 1);
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = (|drv_q) ? DRV : DONE;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      DRV:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    en_d = '0;
    if (state_d == REL)      en_d = rel_d;
    else if (state_d == DRV) en_d = drv_d;

    cur_d   = (cur_oen & ~en_d) | (io_d & en_d);
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  // Datapath and output registers; reset drops any pending strobe immediately
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      rel_q    <= '0;
      drv_q    <= '0;
      cnfg_io  <= '0;
      cnfg_en  <= '0;
      cur_oen  <= RST_OEN;
      ready_q  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      lock_hit <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rel_q    <= rel_d;
      drv_q    <= drv_d;
      cnfg_io  <= io_d;
      cnfg_en  <= en_d;
      cur_oen  <= cur_d;
      ready_q  <= ready_d;
      busy     <= busy_d;
      done     <= done_d;
      lock_hit <= lock_hit_d;
    end
  end

endmodule

// File: tb/tb_pads_oe_sequencer.sv
// Scoreboard bench for pads_oe_sequencer: expected strobe/done events are queued at issue
// and matched by a monitor whenever the DUT strobes cnfg_en or pulses done.
module tb_pads_oe_sequencer;

  localparam int unsigned NPAD = 44;
  localparam logic [43:0] RST  = 44'hC70_003F_FFBD;

  typedef struct {
    bit          is_done;
    logic [43:0] en;
    logic [43:0] io;
    logic [43:0] cur;
    logic        lh;
    int          cyc;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NPAD-1:0] cnfg_io, cnfg_en, cur_oen;
  logic busy, done, lock_hit;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  ev_t  q[$];

  pads_oe_sequencer_if #(.NPAD(NPAD)) bus ();

  pads_oe_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .host     (bus),
    .cnfg_io  (cnfg_io),
    .cnfg_en  (cnfg_en),
    .cur_oen  (cur_oen),
    .busy     (busy),
    .done     (done),
    .lock_hit (lock_hit)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input bit is_done, input logic [43:0] en, input logic [43:0] io,
                      input logic [43:0] cur, input logic lh, input int c);
    ev_t e;
    e.is_done = is_done; e.en = en; e.io = io; e.cur = cur; e.lh = lh; e.cyc = c;
    q.push_back(e);
  endtask

  // Monitor: every strobe or done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!reset && ((cnfg_en != '0) || done)) begin
      if (q.size() == 0) begin
        chk("unexpected_event", 64'(cnfg_en), 64'(0));
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("ev_kind",     64'(done),     64'(e.is_done));
        chk("ev_cycle",    64'(cyc),      64'(e.cyc));
        chk("ev_cnfg_en",  64'(cnfg_en),  64'(e.en));
        chk("ev_cnfg_io",  64'(cnfg_io),  64'(e.io));
        chk("ev_cur_oen",  64'(cur_oen),  64'(e.cur));
        chk("ev_lock_hit", 64'(lock_hit), 64'(e.lh));
      end
    end
  end

  // Present a request once ready; returns the cycle count of the accepting edge
  task automatic issue(input logic [43:0] oen, input logic [43:0] mask,
                       input logic [43:0] lock, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_issue", 64'(bus.req_ready), 64'(1));
    bus.req_valid = 1'b1;
    bus.req_oen   = oen;
    bus.req_mask  = mask;
    bus.lock_mask = lock;
    acc = cyc + 1;
  endtask

  task automatic drop_req(input int hold);
    repeat (1 + hold) @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_oen   = $urandom();
    bus.req_mask  = '1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", 64'(q.size()), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cur_oen"},  64'(cur_oen),       64'(RST));
    chk({tag, "_cnfg_en"},  64'(cnfg_en),       64'(0));
    chk({tag, "_cnfg_io"},  64'(cnfg_io),       64'(0));
    chk({tag, "_ready"},    64'(bus.req_ready), 64'(1));
    chk({tag, "_busy"},     64'(busy),          64'(0));
    chk({tag, "_done"},     64'(done),          64'(0));
    chk({tag, "_lock_hit"}, 64'(lock_hit),      64'(0));
  endtask

  initial begin
    int a;
    bus.req_valid = 1'b0;
    bus.req_oen   = '0;
    bus.req_mask  = '0;
    bus.lock_mask = '0;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_state("reset");
    repeat (4) @(negedge clk);
    chk("idle_cnfg_en", 64'(cnfg_en), 64'(0));

    // Swap: bit1 output->input released, settle, bit2 input->output driven
    issue(44'hC70_003F_FFBB, 44'h000_0000_0006, 44'h0, a);
    push(0, 44'h000_0000_0002, 44'hC70_003F_FFBB, 44'hC70_003F_FFBF, 1'b0, a);
    push(0, 44'h000_0000_0004, 44'hC70_003F_FFBB, 44'hC70_003F_FFBB, 1'b0, a + 5);
    push(1, 44'h0,             44'hC70_003F_FFBB, 44'hC70_003F_FFBB, 1'b0, a + 6);
    drop_req(0);
    @(negedge clk);
    chk("swap_busy_in_wait", 64'(busy), 64'(1));
    drain();

    // Drive-only bits 8..11; valid held one extra cycle while busy must not re-accept
    issue(44'h0, 44'h000_0000_0F00, 44'h0, a);
    push(0, 44'h000_0000_0F00, 44'h0, 44'hC70_003F_F0BB, 1'b0, a);
    push(1, 44'h0,             44'h0, 44'hC70_003F_F0BB, 1'b0, a + 1);
    drop_req(1);
    drain();

    // No-op: every masked target equals the shadow
    issue(44'hC70_003F_F0BB, 44'hFFF_FFFF_FFFF, 44'h0, a);
    push(1, 44'h0, 44'hC70_003F_F0BB, 44'hC70_003F_F0BB, 1'b0, a);
    drop_req(0);
    drain();

    // Locked bit40 is skipped, bit22 released, no drive phase
    issue(44'hD70_007F_F0BB, 44'h100_0040_0000, 44'h380_0000_0000, a);
    push(0, 44'h000_0040_0000, 44'hD70_007F_F0BB, 44'hC70_007F_F0BB, 1'b1, a);
    push(1, 44'h0,             44'hD70_007F_F0BB, 44'hC70_007F_F0BB, 1'b1, a + 5);
    drop_req(0);
    drain();
    chk("lock_hit_held", 64'(lock_hit), 64'(1));

    // Reset during WAIT aborts the pending drive of bit0
    issue(44'hC70_00FF_F0BA, 44'h000_0080_0001, 44'h0, a);
    push(0, 44'h000_0080_0000, 44'hC70_00FF_F0BA, 44'hC70_00FF_F0BB, 1'b0, a);
    drop_req(0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_state("abort");
    repeat (10) @(negedge clk);
    chk("abort_queue", 64'(q.size()), 64'(0));

    // Fresh swap after the abort behaves exactly like the first
    issue(44'hC70_003F_FFBB, 44'h000_0000_0006, 44'h0, a);
    push(0, 44'h000_0000_0002, 44'hC70_003F_FFBB, 44'hC70_003F_FFBF, 1'b0, a);
    push(0, 44'h000_0000_0004, 44'hC70_003F_FFBB, 44'hC70_003F_FFBB, 1'b0, a + 5);
    push(1, 44'h0,             44'hC70_003F_FFBB, 44'hC70_003F_FFBB, 1'b0, a + 6);
    drop_req(0);
    drain();
    chk("final_ready", 64'(bus.req_ready), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pads_oe_sequencer.md
Name: pads_oe_sequencer

Overview:
- Drives the per-pad `cnfg_io`/`cnfg_en` write port of the pad output-enable configuration block.
- Applies host pad-direction change requests in break-before-make order:
  - pads turning output→input are released first;
  - a settle interval follows;
  - pads turning input→output are then driven.
- No pad pair can contend during a direction swap.
- Keeps a shadow copy of every pad's OEN (1 = input, 0 = output) and supports per-pad locking (flash, JTAG).

Parameters:
- NPAD, 44, number of pads.
- SETTLE, 4, idle cycles between release and drive phases; must be ≥1.
- CNTW, 3, width of the settle counter; must satisfy 2^CNTW > SETTLE.
- RST_OEN, 44'hC70_003F_FFBD, shadow OEN after reset; matches the pad block's reset directions.

Ports:
- clk        input   1     system clock
- reset      input   1     synchronous reset, active-high; pad block is fed resetb = ~reset at integration
- req_valid  input   1     host request valid
- req_ready  output  1     sequencer can accept a request
- req_oen    input   NPAD  target OEN per pad
- req_mask   input   NPAD  1 = pad participates in this request
- lock_mask  input   NPAD  1 = pad locked, never changed; sampled at accept
- cnfg_io    output  NPAD  OEN value presented to pad block
- cnfg_en    output  NPAD  per-pad write strobe to pad block
- cur_oen    output  NPAD  shadow of pad block OEN
- busy       output  1     request in progress
- done       output  1     one-cycle pulse when request completes
- lock_hit   output  1     last accepted request touched a locked pad

Behaviour:
- Reset values:
  - state IDLE; req_ready=1; busy=0; done=0; lock_hit=0;
  - cnfg_en=0; cnfg_io=0; cur_oen=RST_OEN; settle counter=0.
- Reset mid-operation aborts immediately: no further cnfg_en strobes, shadow returns to RST_OEN.
- All outputs are registered. req_ready=1 only in IDLE. busy=1 in every state except IDLE.
- Accept occurs when req_valid & req_ready (cycle T). At accept the block latches:
  - tgt = req_oen;
  - eff = req_mask & ~lock_mask;
  - rel = eff & tgt & ~cur_oen (output→input);
  - drv = eff & ~tgt & cur_oen (input→output).
- lock_hit is updated at T+1 to |(req_mask & lock_mask) and held until the next accept.
- Pads whose target equals the shadow are never strobed.
- FSM states: IDLE, REL, WAIT, DRV, DONE.
  - IDLE→REL if rel≠0; else →DRV if drv≠0; else →DONE.
  - REL (1 cycle): cnfg_en=rel, cnfg_io=tgt; cur_oen updates to (cur_oen & ~rel) | (tgt & rel) in the same edge. →WAIT, counter loads SETTLE-1.
  - WAIT: counter decrements each cycle; at 0 → DRV if drv≠0, else →DONE. WAIT lasts exactly SETTLE cycles.
  - DRV (1 cycle): cnfg_en=drv, cnfg_io=tgt; cur_oen updated analogously. →DONE.
  - DONE (1 cycle): done=1. →IDLE.
- cnfg_en=0 in every state except REL/DRV. cnfg_io holds tgt from accept until the next accept.
- Latency for a full request accepted at T: REL at T+1, WAIT at T+2..T+1+SETTLE, DRV at T+2+SETTLE, done at T+3+SETTLE, req_ready again at T+4+SETTLE.
- Since the pad block registers on cnfg_en, its OEN equals cur_oen one cycle after each strobe.
- req_valid while busy is ignored (no accept); the host must hold the request.

Test Plan:
- Reset, no requests -> cur_oen=44'hC70_003F_FFBD, cnfg_en=0, req_ready=1, done never asserted.
- Swap: req_mask=bits{1,2}, req_oen bit1=1 bit2=0 (SDO→input, SDI→output), SETTLE=4, accept at T:
  - T+1: cnfg_en=bit1 only;
  - T+6: cnfg_en=bit2 only;
  - T+7: done=1;
  - then cur_oen bit1=1, bit2=0, all other bits unchanged.
- Drive-only request turning bits 8..11 to output:
  - no REL/WAIT;
  - T+1: cnfg_en=0x00000000F00;
  - T+2: done=1.
- No-op request (req_oen equals cur_oen on all masked pads) -> cnfg_en stays 0, done=1 at T+1, lock_hit=0.
- lock_mask=bits 39..41, request sets bit40=1 and bit22=1:
  - only bit22 released;
  - lock_hit=1 from T+1;
  - cur_oen bit40 stays 0.
- reset asserted during WAIT -> next cycle state IDLE, cnfg_en=0 for all following cycles, cur_oen=RST_OEN; a new request is then accepted normally.
